inst_fetch: RTL and testbench

Instruction fetch unit: owns the program counter, issues read requests to instruction memory over a req/ack handshake, and presents each fetched instruction with its incremented PC to the IF/ID pipeline register. It is the producer side of the IF/ID interface: it drives the instruction and PC+1 that IF/ID captures, and honours the same pause and branch-redirect controls from the hazard/branch units. When no instruction is available, it presents a NOP bubble.

---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_skid_buf.sv | 29 ++
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared IF definitions: bus widths, NOP encoding, pause levels, IF states.
// Optional skid buffer build macro: INST_SKID_EN.
package inst_fetch_pkg;

  localparam int PC_BUS   = 16;
  localparam int INST_BUS = 16;

  localparam logic [INST_BUS-1:0] INST_ZERO = '0;

  localparam logic PAUSE_DISABLE = 1'b0;
  localparam logic PAUSE_ENABLE  = 1'b1;

  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_REQ  = 2'd1;
  localparam logic [1:0] IF_WAIT = 2'd2;
  localparam logic [1:0] IF_DROP = 2'd3;

  // Entries held (slot + skid) after the coming edge.
  function automatic logic [1:0] occ_after(
    input logic full,
    input logic skid,
    input logic take,
    input logic consume
  );
    return 2'(full) + 2'(skid) + 2'(take) - 2'(consume);
  endfunction

endpackage

// File: rtl/inst_skid_buf.sv
// One-entry skid store for fetched {instruction, pc+1} pairs.
// Holds all-zero data whenever empty.
module inst_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk_50MHz,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge clk_50MHz) begin
    if (!rst || clr) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
      dout  <= '0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, req/ack memory handshake, IF/ID producer slot.
// Build with INST_SKID_EN for a one-entry skid buffer (1 inst/cycle).
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              PC_W     = PC_BUS,
  parameter int              INST_W   = INST_BUS,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              if_pause,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] ram_out_inst,
  output logic [PC_W-1:0]   pc_add_value,
  output logic              if_valid
);

  localparam int ENT_W = INST_W + PC_W;
  localparam logic [INST_W-1:0] NOP = INST_W'(INST_ZERO);

  logic [1:0]       state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  drop_addr;
  logic [PC_W-1:0]  pc_inc;
  logic             consume;
  logic             take;
  logic             outstanding;
  logic             room;
  logic             skid_valid;
  logic [ENT_W-1:0] skid_data;

  assign pc_inc      = pc + PC_W'(1);
  assign consume     = if_valid && (if_pause != PAUSE_ENABLE);
  assign take        = (state == IF_REQ) && mem_ack;
  assign outstanding = (state == IF_REQ) || (state == IF_DROP);

  assign mem_req  = outstanding;
  assign mem_addr = (state == IF_DROP) ? drop_addr : pc;

`ifdef INST_SKID_EN
  localparam logic [1:0] CAP = 2'd2;

  logic skid_push;
  logic skid_pop;

  assign skid_push = take && if_valid && !consume;
  assign skid_pop  = consume && skid_valid;

  inst_skid_buf #(.W(ENT_W)) u_skid (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .clr       (br_taken),
    .push      (skid_push),
    .pop       (skid_pop),
    .din       ({mem_rdata, pc_inc}),
    .dout      (skid_data),
    .valid     (skid_valid)
  );
`else
  localparam logic [1:0] CAP = 2'd1;

  assign skid_valid = 1'b0;
  assign skid_data  = '0;
`endif

  assign room = occ_after(if_valid, skid_valid, take, consume) < CAP;

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state        <= IF_IDLE;
      pc           <= RESET_PC;
      drop_addr    <= RESET_PC;
      ram_out_inst <= NOP;
      pc_add_value <= '0;
      if_valid     <= 1'b0;
    end else if (br_taken) begin
      // Any in-flight return belongs to the old stream.
      pc           <= br_target;
      ram_out_inst <= NOP;
      pc_add_value <= '0;
      if_valid     <= 1'b0;
      if (state != IF_DROP)
        drop_addr <= pc;
      if (outstanding && !mem_ack)
        state <= IF_DROP;
      else
        state <= IF_REQ;
    end else begin
      if (take)
        pc <= pc_inc;
      if (take && (!if_valid || consume)) begin
        ram_out_inst <= mem_rdata;
        pc_add_value <= pc_inc;
        if_valid     <= 1'b1;
      end else if (consume) begin
        if_valid <= skid_valid;
        if (skid_valid)
          {ram_out_inst, pc_add_value} <= skid_data;
        else begin
          ram_out_inst <= NOP;
          pc_add_value <= '0;
        end
      end
      unique case (state)
        IF_IDLE: state <= IF_REQ;
        IF_REQ:  if (take && !room) state <= IF_WAIT;
        IF_WAIT: if (room) state <= IF_REQ;
        IF_DROP: if (mem_ack) state <= IF_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
// Table covers the default build; skid build adds its own sequence.
module tb_inst_fetch;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        if_pause = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ram_out_inst;
  logic [15:0] pc_add_value;
  logic        if_valid;

  int n_chk = 0;
  int n_fail = 0;

  inst_fetch #(
    .PC_W     (16),
    .INST_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .if_pause     (if_pause),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ram_out_inst (ram_out_inst),
    .pc_add_value (pc_add_value),
    .if_valid     (if_valid)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic        rst;
    logic        pause;
    logic        br;
    logic [15:0] tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] inst;
    logic [15:0] pc1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rs, input logic pz, input logic br,
    input logic [15:0] tg, input logic ak,
    input logic [15:0] rd, input logic rq,
    input logic [15:0] ad, input logic vl,
    input logic [15:0] in, input logic [15:0] p1
  );
    vec_t v;
    v.rst = rs; v.pause = pz; v.br = br;
    v.tgt = tg; v.ack = ak; v.rdata = rd;
    v.req = rq; v.addr = ad; v.valid = vl;
    v.inst = in; v.pc1 = p1;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; if_pause = v.pause;
    br_taken = v.br; br_target = v.tgt;
    mem_ack = v.ack; mem_rdata = v.rdata;
  endtask

  task automatic idle_in();
    if_pause = 1'b0; br_taken = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic outs(
    input string tag, input logic rq,
    input logic [15:0] ad, input logic vl,
    input logic [15:0] in, input logic [15:0] p1
  );
    chk({tag, ".req"}, 16'(mem_req), 16'(rq));
    if (rq)
      chk({tag, ".addr"}, mem_addr, ad);
    chk({tag, ".valid"}, 16'(if_valid), 16'(vl));
    chk({tag, ".inst"}, ram_out_inst, in);
    chk({tag, ".pc1"}, pc_add_value, p1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int k;
    bit got;
`ifndef INST_SKID_EN
    tbl.push_back(mk(0,0,0,'0,0,'0,       0,16'h0000,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0000,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hA000, 0,16'h0001,1,16'hA000,16'h0001));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0001,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hA001, 0,16'h0002,1,16'hA001,16'h0002));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0002,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hA002, 0,16'h0003,1,16'hA002,16'h0003));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,0,'0,0,'0,     0,16'h0003,1,16'hA002,16'h0003));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0003,0,'0,'0));
    tbl.push_back(mk(1,0,1,16'h0010,0,'0, 1,16'h0003,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hFFFF, 1,16'h0010,0,'0,'0));
    tbl.push_back(mk(1,0,1,16'h0040,0,'0, 1,16'h0010,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0010,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0010,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hBAD0, 1,16'h0040,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hC040, 0,16'h0041,1,16'hC040,16'h0041));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0041,0,'0,'0));
    tbl.push_back(mk(1,0,1,16'hFFFF,1,16'hDEAD, 1,16'hFFFF,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'hE000, 0,16'h0000,1,16'hE000,16'h0000));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0000,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'h1234, 0,16'h0001,1,16'h1234,16'h0001));
    tbl.push_back(mk(1,1,1,16'h0080,0,'0, 1,16'h0080,0,'0,'0));
    tbl.push_back(mk(0,0,0,'0,0,'0,       0,16'h0000,0,'0,'0));
    tbl.push_back(mk(0,0,0,'0,1,16'h5555, 0,16'h0000,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,0,'0,       1,16'h0000,0,'0,'0));
    tbl.push_back(mk(1,0,0,'0,1,16'h7777, 0,16'h0001,1,16'h7777,16'h0001));
    #5;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      outs($sformatf("row%0d", i), tbl[i].req,
           tbl[i].addr, tbl[i].valid,
           tbl[i].inst, tbl[i].pc1);
    end
`else
    // Skid: an ack while paused is absorbed, then issue stops.
    #5;
    rst = 1'b0; idle_in(); step();
    outs("sk.rst", 0, 16'h0000, 0, '0, '0);
    rst = 1'b1; step();
    outs("sk.req0", 1, 16'h0000, 0, '0, '0);
    mem_ack = 1'b1; mem_rdata = 16'hAAAA; step();
    outs("sk.ackA", 1, 16'h0001, 1, 16'hAAAA, 16'h0001);
    if_pause = 1'b1; mem_rdata = 16'hBBBB; step();
    outs("sk.ackB", 0, '0, 1, 16'hAAAA, 16'h0001);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      outs($sformatf("sk.hold%0d", i), 0, '0, 1,
           16'hAAAA, 16'h0001);
    end
    if_pause = 1'b0; step();
    outs("sk.drain", 1, 16'h0002, 1, 16'hBBBB, 16'h0002);
`endif
    // Zero-wait responder from reset: sequential addresses.
    idle_in();
    rst = 1'b0; step();
    rst = 1'b1;
    for (k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        if (mem_req) got = 1'b1;
        else step();
      end
      if (!got) begin
        n_chk++; n_fail++;
        $display("FAIL seq%0d.timeout: got no req, expected req", k);
      end else begin
        chk($sformatf("seq%0d.addr", k), mem_addr, 16'(k));
        mem_ack = 1'b1;
        mem_rdata = 16'hA5A0 + 16'(k);
        step();
        mem_ack = 1'b0;
        chk($sformatf("seq%0d.valid", k), 16'(if_valid), 16'h1);
        chk($sformatf("seq%0d.inst", k), ram_out_inst,
            16'hA5A0 + 16'(k));
        chk($sformatf("seq%0d.pc1", k), pc_add_value,
            16'(k + 1));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
